modexp_stream_ctrl: RTL and testbench

- Streaming front-end for the modular-exponentiation engine. Computes c = m^e mod n for a stream of message words.
- Holds the key pair (e, n) and accepts message words over a valid/ready input.
- Per word: range-checks it, launches the engine with a one-cycle set pulse, waits for finished, registers the result.
- Presents the result over a valid/ready output. Sits between the message source and the ciphertext sink; the engine is a sibling instance wired through the exp_* ports.

---
 rtl/modexp_pkg.sv | 18 +
 rtl/modexp_out_reg.sv | 33 +++
 rtl/modexp_stream_ctrl.sv | 150 +++++++++++++++
 tb/tb_modexp_stream_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// rtl/modexp_pkg.sv - shared state encoding and sizing helpers for the modexp stream controller
package modexp_pkg;

  localparam int MODEXP_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } modexp_state_e;

  // Width of a counter that must reach timeout_cycles inclusive.
  function automatic int modexp_cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/modexp_out_reg.sv
// rtl/modexp_out_reg.sv - result holding register with valid/ready consume
module modexp_out_reg
  import modexp_pkg::*;
#(
  parameter int DATA_WIDTH = MODEXP_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_err,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  // Load a result, hold it until the sink takes it; data stays put after the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_err   <= load_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/modexp_stream_ctrl.sv
// rtl/modexp_stream_ctrl.sv - streaming front-end for the modexp engine (optional MODEXP_TIMEOUT_EN)
module modexp_stream_ctrl
  import modexp_pkg::*;
#(
  parameter int DATA_WIDTH     = MODEXP_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 2*DATA_WIDTH+4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_load,
  input  logic [DATA_WIDTH-1:0] key_exp,
  input  logic [DATA_WIDTH-1:0] key_mod,
  output logic                  key_ok,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  busy,
  output logic                  exp_set,
  output logic [DATA_WIDTH-1:0] exp_a,
  output logic [DATA_WIDTH-1:0] exp_b,
  output logic [DATA_WIDTH-1:0] exp_mod,
  input  logic [DATA_WIDTH-1:0] exp_out,
  input  logic                  exp_finished
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] LAUNCH = ST_LAUNCH;
  localparam logic [1:0] WAIT   = ST_WAIT;
  localparam logic [1:0] HOLD   = ST_HOLD;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] key_exp_q;
  logic [DATA_WIDTH-1:0] key_mod_q;
  logic [DATA_WIDTH-1:0] msg_q;
  logic                  key_ok_q;
  logic                  accept;
  logic                  timed_out;
  logic                  out_load;
  logic [DATA_WIDTH-1:0] out_load_data;
  logic                  out_load_err;

  // A key load in the same cycle as an offered word takes priority.
  assign in_ready = (state == IDLE) & key_ok_q & ~key_load & ~out_valid;
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);
  assign exp_set  = (state == LAUNCH);
  assign exp_a    = msg_q;
  assign exp_b    = key_exp_q;
  assign exp_mod  = key_mod_q;
  assign key_ok   = key_ok_q;

`ifdef MODEXP_TIMEOUT_EN
  localparam int CNT_W = modexp_cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count WAIT cycles; each launch starts a fresh count.
  always_ff @(posedge clock) begin
    if (reset || state == LAUNCH) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  // Next-state and result-load decode; exp_finished is ignored in LAUNCH where it may be stale.
  always_comb begin
    state_nxt     = state;
    out_load      = 1'b0;
    out_load_data = '0;
    out_load_err  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_data >= key_mod_q) begin
            state_nxt    = HOLD;
            out_load     = 1'b1;
            out_load_err = 1'b1;
          end else begin
            state_nxt = LAUNCH;
          end
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (exp_finished) begin
          state_nxt     = HOLD;
          out_load      = 1'b1;
          out_load_data = exp_out;
        end else if (timed_out) begin
          state_nxt    = HOLD;
          out_load     = 1'b1;
          out_load_err = 1'b1;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, key and message registers; keys only change while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      key_exp_q <= '0;
      key_mod_q <= '0;
      key_ok_q  <= 1'b0;
      msg_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && key_load) begin
        key_exp_q <= key_exp;
        key_mod_q <= key_mod;
        key_ok_q  <= (key_mod >= DATA_WIDTH'(2));
      end
      if (accept) begin
        msg_q <= in_data;
      end
    end
  end

  modexp_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (out_load),
    .load_data (out_load_data),
    .load_err  (out_load_err),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err)
  );

endmodule

// File: tb/tb_modexp_stream_ctrl.sv
// tb/tb_modexp_stream_ctrl.sv - directed self-checking bench for modexp_stream_ctrl
module tb_modexp_stream_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_load = 1'b0;
  logic [7:0] key_exp = 8'd0;
  logic [7:0] key_mod = 8'd0;
  logic       key_ok;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_err;
  logic       busy;
  logic       exp_set;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic [7:0] exp_mod;
  logic [7:0] exp_out = 8'hAA;
  logic       exp_finished = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  modexp_stream_ctrl #(
    .DATA_WIDTH(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key_load     (key_load),
    .key_exp      (key_exp),
    .key_mod      (key_mod),
    .key_ok       (key_ok),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err),
    .busy         (busy),
    .exp_set      (exp_set),
    .exp_a        (exp_a),
    .exp_b        (exp_b),
    .exp_mod      (exp_mod),
    .exp_out      (exp_out),
    .exp_finished (exp_finished)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pow_mod(input logic [7:0] b, input logic [7:0] e, input logic [7:0] n);
    int r;
    if (n == 8'd0) return 8'd0;
    r = 1 % int'(n);
    for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(n);
    return 8'(r);
  endfunction

  // Engine model: finished stays at its old level until the set pulse is seen.
  int         eng_delay = 3;
  bit         eng_hang = 1'b0;
  int         eng_cnt = 0;
  logic [7:0] eng_res = 8'd0;

  always @(posedge clock) begin
    if (exp_set) begin
      eng_res      <= pow_mod(exp_a, exp_b, exp_mod);
      eng_cnt      <= eng_delay;
      exp_finished <= 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_hang) begin
        exp_finished <= 1'b1;
        exp_out      <= eng_res;
      end
    end
  end

  int set_pulses = 0;
  int set_run = 0;
  int set_run_max = 0;

  always @(negedge clock) begin
    if (exp_set) begin
      set_pulses++;
      set_run++;
      if (set_run > set_run_max) set_run_max = set_run;
    end else begin
      set_run = 0;
    end
  end

  task automatic load_key(input logic [7:0] e, input logic [7:0] n);
    @(negedge clock);
    key_load = 1'b1;
    key_exp  = e;
    key_mod  = n;
    @(negedge clock);
    key_load = 1'b0;
  endtask

  task automatic send_word(input string tag, input logic [7:0] m, input logic [7:0] exp_data,
                           input logic exp_err, input int exp_lat, input int hold,
                           input bit busy_key, input int exp_sets);
    int n;
    int k;
    int sets0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    sets0    = set_pulses;
    in_valid = 1'b1;
    in_data  = m;
    @(negedge clock);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 100) begin
      @(negedge clock);
      k++;
      if (busy_key && k == 2) begin
        key_load = 1'b1;
        key_exp  = 8'd0;
        key_mod  = 8'd5;
      end else begin
        key_load = 1'b0;
      end
    end
    key_load = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_data"}, 32'(out_data), 32'(exp_data));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_set_pulses"}, 32'(set_pulses - sets0), 32'(exp_sets));
  endtask

  initial begin
    bit spurious;
    repeat (3) @(negedge clock);
    check("rst_key_ok", 32'(key_ok), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_exp_set", 32'(exp_set), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_exp_abm", {8'd0, exp_a, exp_b, exp_mod}, 32'd0);
    reset = 1'b0;

    load_key(8'd3, 8'd33);
    check("key_ok_33", 32'(key_ok), 32'd1);
    check("exp_mod_33", 32'(exp_mod), 32'd33);

    send_word("m4", 8'd4, 8'd31, 1'b0, 6, 0, 1'b0, 1);
    check("stale_finished", 32'(exp_finished), 32'd1);
    send_word("m2_stale", 8'd2, 8'd8, 1'b0, 6, 0, 1'b0, 1);
    check("set_width", 32'(set_run_max), 32'd1);
    send_word("m0", 8'd0, 8'd0, 1'b0, 6, 0, 1'b0, 1);
    send_word("range40", 8'd40, 8'd0, 1'b1, 1, 0, 1'b0, 0);
    send_word("range33", 8'd33, 8'd0, 1'b1, 1, 0, 1'b0, 0);
    send_word("m32", 8'd32, 8'd32, 1'b0, 6, 0, 1'b0, 1);
    send_word("backpressure", 8'd4, 8'd31, 1'b0, 6, 5, 1'b0, 1);
    send_word("key_busy", 8'd4, 8'd31, 1'b0, 6, 0, 1'b1, 1);
    check("key_busy_key_ok", 32'(key_ok), 32'd1);
    check("key_busy_exp_b", 32'(exp_b), 32'd3);
    send_word("old_key", 8'd2, 8'd8, 1'b0, 6, 0, 1'b0, 1);

    load_key(8'd0, 8'd33);
    send_word("e0", 8'd5, 8'd1, 1'b0, 6, 0, 1'b0, 1);

    load_key(8'd3, 8'd1);
    check("key_mod1_key_ok", 32'(key_ok), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("key_mod1_in_ready", 32'(in_ready), 32'd0);
      check("key_mod1_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    load_key(8'd3, 8'd33);
    eng_delay = 6;
    @(negedge clock);
    check("rstwait_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'd4;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    check("rstwait_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rstwait_busy", 32'(busy), 32'd0);
    check("rstwait_out_valid", 32'(out_valid), 32'd0);
    check("rstwait_key_ok", 32'(key_ok), 32'd0);
    check("rstwait_in_ready", 32'(in_ready), 32'd0);
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (out_valid || busy) spurious = 1'b1;
    end
    check("rstwait_spurious", 32'(spurious), 32'd0);
    eng_delay = 3;
    load_key(8'd3, 8'd33);
    send_word("after_rst", 8'd2, 8'd8, 1'b0, 6, 0, 1'b0, 1);

`ifdef MODEXP_TIMEOUT_EN
    eng_hang = 1'b1;
    send_word("timeout", 8'd4, 8'd0, 1'b1, 22, 0, 1'b0, 1);
    eng_hang = 1'b0;
    send_word("after_timeout", 8'd4, 8'd31, 1'b0, 6, 0, 1'b0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
